c_lfsr_checker: RTL and testbench

- Receive-side checker for LFSR-generated pseudo-random word streams, such as PRBS link-test patterns produced by a multi-input LFSR generator elsewhere in clib.
- Self-synchronizes by seeding its local LFSR from a received word, then confirms lock over a configurable number of matching words.
- While locked, it flags mismatching words and keeps a saturating error count.
- Sits at the far end of a channel or link, alongside the receive datapath.

---
 rtl/c_lfsr_checker_if.sv | 24 ++
 rtl/c_lfsr_checker.sv | 117 +++++++++++
 tb/tb_c_lfsr_checker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/c_lfsr_checker_if.sv
// Receive-side bundle for the LFSR stream checker: word input, tap mask,
// error-count clear and the lock/error status returned by the checker.
interface c_lfsr_checker_if #(
    parameter int width       = 16,
    parameter int count_width = 16
) ();
    logic [0:width-1]       feedback;
    logic                   active;
    logic [0:width-1]       data_in;
    logic                   clear_errors;
    logic                   locked;
    logic                   error;
    logic [0:count_width-1] error_count;

    modport master (
        output feedback, active, data_in, clear_errors,
        input  locked, error, error_count
    );

    modport slave (
        input  feedback, active, data_in, clear_errors,
        output locked, error, error_count
    );
endinterface

// File: rtl/c_lfsr_checker.sv
// Self-synchronizing PRBS checker: seeds from the received stream, confirms lock
// over lock_count matching words, then counts mismatches until lock is lost.
module c_lfsr_checker #(
    parameter int width        = 16,
    parameter int iterations   = 1,
    parameter int lock_count   = 8,
    parameter int unlock_count = 4,
    parameter int count_width  = 16
) (
    input logic               clk,
    input logic               reset,
    c_lfsr_checker_if.slave   bus
);
    localparam int MC_W = $clog2(lock_count + 1);
    localparam int UC_W = $clog2(unlock_count + 1);
    localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(lock_count - 1);
    localparam logic [UC_W-1:0] UNLOCK_LAST = UC_W'(unlock_count - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]             r_state;
    logic [0:width-1]       r_lfsr;
    logic [MC_W-1:0]        r_match_cnt;
    logic [UC_W-1:0]        r_miss_cnt;
    logic                   r_error;
    logic [0:count_width-1] r_error_count;

    logic [0:width-1]       w_expect;
    logic                   w_match;
    logic                   w_zero;
    logic                   w_count_inc;

    function automatic logic [0:width-1] lfsr_step(input logic [0:width-1] s,
                                                   input logic [0:width-1] fb);
        lfsr_step = {^(s & fb), s[0:width-2]};
    endfunction

    function automatic logic [0:count_width-1] sat_inc(input logic [0:count_width-1] c);
        sat_inc = (&c) ? c : c + 1'b1;
    endfunction

    // Expected word is the held state advanced by the generator's step count.
    always_comb begin
        w_expect = r_lfsr;
        for (int i = 0; i < iterations; i++)
            w_expect = lfsr_step(w_expect, bus.feedback);
    end

    assign w_match     = (bus.data_in == w_expect);
    assign w_zero      = (bus.data_in == '0);
    assign w_count_inc = bus.active && (r_state == ST_LOCKED) && !w_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_SEARCH;
            r_lfsr        <= '0;
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_error       <= 1'b0;
            r_error_count <= '0;
        end else begin
            r_error <= 1'b0;
            if (bus.active) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (!w_zero) begin
                            r_lfsr      <= bus.data_in;
                            r_match_cnt <= '0;
                            r_state     <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_match) begin
                            r_lfsr <= bus.data_in;
                            if (r_match_cnt == LOCK_LAST) begin
                                r_state    <= ST_LOCKED;
                                r_miss_cnt <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else if (w_zero) begin
                            r_state <= ST_SEARCH;
                        end else begin
                            r_lfsr      <= bus.data_in;
                            r_match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run from the local state so corrupted words never reseed.
                        r_lfsr <= w_expect;
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_error <= 1'b1;
                            if (r_miss_cnt == UNLOCK_LAST)
                                r_state <= ST_SEARCH;
                            else
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end

            if (bus.clear_errors)
                r_error_count <= w_count_inc ? count_width'(1) : '0;
            else if (w_count_inc)
                r_error_count <= sat_inc(r_error_count);
        end
    end

    assign bus.locked      = (r_state == ST_LOCKED);
    assign bus.error       = r_error;
    assign bus.error_count = r_error_count;
endmodule

// File: tb/tb_c_lfsr_checker.sv
// Bench for c_lfsr_checker: two instances (A: unlock 3, 16-bit count; B: unlock 8,
// 2-bit count) share one stimulus stream and are compared against a behavioural model.
module tb_c_lfsr_checker;
    localparam int W    = 4;
    localparam int LOCK = 3;
    localparam int UNL  [2] = '{3, 8};
    localparam int CMAX [2] = '{65535, 3};

    logic       clk;
    logic       rst_n;
    logic       act;
    logic [3:0] din;
    logic       clr;
    logic [3:0] fb;

    int checks;
    int errors;

    c_lfsr_checker_if #(.width(W), .count_width(16)) ifa ();
    c_lfsr_checker_if #(.width(W), .count_width(2))  ifb ();

    assign ifa.active = act;  assign ifa.data_in = din;
    assign ifa.clear_errors = clr;  assign ifa.feedback = fb;
    assign ifb.active = act;  assign ifb.data_in = din;
    assign ifb.clear_errors = clr;  assign ifb.feedback = fb;

    c_lfsr_checker #(.width(W), .iterations(1), .lock_count(LOCK),
                     .unlock_count(3), .count_width(16)) dut_a (
        .clk(clk), .reset(rst_n), .bus(ifa));
    c_lfsr_checker #(.width(W), .iterations(1), .lock_count(LOCK),
                     .unlock_count(8), .count_width(2)) dut_b (
        .clk(clk), .reset(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 0 = searching, 1 = verifying, 2 = locked.
    int m_st [2];
    int m_lfsr [2];
    int m_mc [2];
    int m_mm [2];
    int m_err [2];
    int m_cnt [2];

    // Numeric view: literal bit 0 is the MSB, so a step is a right shift with
    // the parity of the tapped bits entering at the top.
    function automatic int next_word(input int s, input int f);
        int p;
        p = 0;
        for (int b = 0; b < W; b++) p ^= ((s & f) >> b) & 1;
        return (p << (W - 1)) | (s >> 1);
    endfunction

    task automatic model_cycle(input int k);
        int  e;
        int  d;
        bit  mis;
        e   = next_word(m_lfsr[k], int'(fb));
        d   = int'(din);
        mis = 1'b0;
        m_err[k] = 0;
        if (act) begin
            if (m_st[k] == 0) begin
                if (d != 0) begin m_lfsr[k] = d; m_mc[k] = 0; m_st[k] = 1; end
            end else if (m_st[k] == 1) begin
                if (d == e) begin
                    m_lfsr[k] = d; m_mc[k]++;
                    if (m_mc[k] == LOCK) begin m_st[k] = 2; m_mm[k] = 0; end
                end else if (d == 0) m_st[k] = 0;
                else begin m_lfsr[k] = d; m_mc[k] = 0; end
            end else begin
                m_lfsr[k] = e;
                if (d == e) m_mm[k] = 0;
                else begin
                    mis = 1'b1; m_err[k] = 1; m_mm[k]++;
                    if (m_mm[k] == UNL[k]) m_st[k] = 0;
                end
            end
        end
        if (clr) m_cnt[k] = mis ? 1 : 0;
        else if (mis && m_cnt[k] < CMAX[k]) m_cnt[k]++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k] = 0; m_lfsr[k] = 0; m_mc[k] = 0;
                m_mm[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
            end else begin
                model_cycle(k);
            end
        end
    end

    task automatic cmp(input string nm, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, actual, required, $time);
        end
    endtask

    function automatic int dut_lk(input int k);
        return (k == 0) ? int'(ifa.locked) : int'(ifb.locked);
    endfunction
    function automatic int dut_er(input int k);
        return (k == 0) ? int'(ifa.error) : int'(ifb.error);
    endfunction
    function automatic int dut_ct(input int k);
        return (k == 0) ? int'(ifa.error_count) : int'(ifb.error_count);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("model_locked[%0d]", k), dut_lk(k), (m_st[k] == 2) ? 1 : 0);
            cmp($sformatf("model_error[%0d]", k), dut_er(k), m_err[k]);
            cmp($sformatf("model_count[%0d]", k), dut_ct(k), m_cnt[k]);
        end
    end

    task automatic chk(input string nm, input int k, input int lk, input int er, input int ct);
        cmp({nm, "_locked"}, dut_lk(k), lk);
        cmp({nm, "_error"}, dut_er(k), er);
        cmp({nm, "_count"}, dut_ct(k), ct);
    endtask

    task automatic send(input logic a, input logic [3:0] d, input logic c);
        @(negedge clk);
        act = a; din = d; clr = c;
        @(posedge clk);
        #1;
        act = 1'b0; clr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; act = 1'b0; din = 4'b0000; clr = 1'b0; fb = 4'b0011;
        repeat (2) @(negedge clk);
        chk("reset_a", 0, 0, 0, 0);
        chk("reset_b", 1, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Acquisition.
        send(1, 4'b1000, 0); chk("acq_w1", 0, 0, 0, 0);
        send(1, 4'b0100, 0); chk("acq_w2", 0, 0, 0, 0);
        send(1, 4'b0010, 0); chk("acq_w3", 0, 0, 0, 0);
        send(1, 4'b1001, 0); chk("acq_w4", 0, 1, 0, 0);

        // Single corrupted word while locked.
        send(1, 4'b0000, 0); chk("single_err_a", 0, 1, 1, 1);
        chk("single_err_b", 1, 1, 1, 1);
        send(1, 4'b0110, 0); chk("after_err1", 0, 1, 0, 1);
        send(1, 4'b1011, 0); chk("after_err2", 0, 1, 0, 1);

        // Clear on an idle cycle, then three wrong words drop lock on A.
        send(0, 4'b0000, 1); chk("clear_idle_a", 0, 1, 0, 0);
        chk("clear_idle_b", 1, 1, 0, 0);
        send(1, 4'b0000, 0); chk("unlock_m1", 0, 1, 1, 1);
        send(1, 4'b0000, 0); chk("unlock_m2", 0, 1, 1, 2);
        send(1, 4'b0000, 0); chk("unlock_m3", 0, 0, 1, 3);
        chk("sat_b3", 1, 1, 1, 3);

        // Zero words keep A searching; B saturates its 2-bit count.
        send(1, 4'b0000, 0); chk("zero_seed1", 0, 0, 0, 3);
        chk("sat_b4", 1, 1, 1, 3);
        send(1, 4'b0000, 0); chk("zero_seed2", 0, 0, 0, 3);
        chk("sat_b5", 1, 1, 1, 3);

        // Clear coinciding with a mismatch leaves a count of one.
        send(1, 4'b0000, 1); chk("clr_mis_b", 1, 1, 1, 1);
        chk("clr_search_a", 0, 0, 0, 0);

        // Reacquire with idle gaps between words.
        send(1, 4'b1000, 0); send(0, 4'b1111, 0);
        send(1, 4'b0100, 0); send(0, 4'b0000, 0); send(0, 4'b0000, 0);
        send(1, 4'b0010, 0); chk("gap_w3", 0, 0, 0, 0);
        send(0, 4'b0101, 0); chk("gap_idle", 0, 0, 0, 0);
        send(1, 4'b1001, 0); chk("gap_lock", 0, 1, 0, 0);

        // Two errors, then asynchronous reset between clock edges.
        send(1, 4'b0000, 0);
        send(1, 4'b0000, 0); chk("pre_reset", 0, 1, 1, 2);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_a", 0, 0, 0, 0);
        chk("async_reset_b", 1, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Reseed inside VERIFY, then lock on the new seed.
        send(1, 4'b1000, 0); chk("rs_w1", 0, 0, 0, 0);
        send(1, 4'b0100, 0); chk("rs_w2", 0, 0, 0, 0);
        send(1, 4'b1111, 0); chk("rs_reseed", 0, 0, 0, 0);
        send(1, 4'b0111, 0); chk("rs_w4", 0, 0, 0, 0);
        send(1, 4'b0011, 0); chk("rs_w5", 0, 0, 0, 0);
        send(1, 4'b0001, 0); chk("rs_lock", 0, 1, 0, 0);
        send(1, 4'b1000, 0); chk("rs_track", 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
